analog_stick_scanner: RTL and testbench
=======================================

ANALOG_STICK_SCANNER -- requirements
Module: analog_stick_scanner

Interface
REQ-001 SHALL have parameter NUM_CH, default 2 (legal range 1..8): number of XADC auxiliary channels scanned.
REQ-002 SHALL have parameter ADDR_BASE, default 7'h16: DRP address of channel 0; channel k is read at ADDR_BASE+k.
REQ-003 SHALL have parameter SAMPLE_W, default 12: sample width, taken from drp_do[15:16-SAMPLE_W].
REQ-004 SHALL have parameters TH_LOW, default 1000, and TH_HIGH, default 3000: direction thresholds.
REQ-005 SHALL have parameter HYST, default 100: hysteresis band; elaboration SHALL fail unless TH_LOW+HYST < TH_HIGH-HYST.
REQ-006 SHALL have parameter AVG_SHIFT, default 2 (range 0..4): IIR filter shift.
REQ-007 SHALL have parameters SCAN_DIV, default 1000 (cycles between scan starts), and TIMEOUT, default 255 (max drdy wait cycles).
REQ-008 clk_100MHz  in  1  sole clock; all logic on its rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 scan_en  in  1  enables scan starts.
REQ-011 drp_daddr  out  7; drp_den  out  1; drp_drdy  in  1; drp_do  in  16: DRP master port to the external XADC.
REQ-012 sample_data  out  NUM_CH*SAMPLE_W  filtered samples, channel k in bits [k*SAMPLE_W +: SAMPLE_W].
REQ-013 dir_lo, dir_hi  out  NUM_CH each  per-channel direction levels.
REQ-014 lo_pulse, hi_pulse  out  NUM_CH each  one-cycle press pulses.
REQ-015 scan_done  out  1  one-cycle pulse at end of each scan; timeout_err  out  1  sticky DRP-timeout flag.

Function
REQ-016 Scan timer SHALL count 0..SCAN_DIV-1 continuously; at wrap, a scan SHALL start only if state is IDLE and scan_en=1; otherwise that tick is dropped.
REQ-017 FSM states IDLE -> ISSUE -> WAIT -> UPDATE -> (ISSUE for next channel | DONE) -> IDLE; channel index starts at 0 every scan.
REQ-018 ISSUE SHALL drive drp_den=1 for exactly one cycle with drp_daddr=ADDR_BASE+ch; drp_daddr SHALL hold until the channel leaves WAIT.
REQ-019 WAIT SHALL capture drp_do on the first cycle drp_drdy=1 and go to UPDATE; drp_drdy in any other state SHALL be ignored.
REQ-020 If drdy is absent for TIMEOUT cycles in WAIT, timeout_err SHALL set, that channel's filter and directions SHALL remain unchanged, and the FSM SHALL advance to the next channel.
REQ-021 Filter: accumulator width SAMPLE_W+AVG_SHIFT; acc <= acc - (acc>>AVG_SHIFT) + raw; filtered = acc>>AVG_SHIFT; first valid sample per channel after reset SHALL load acc = raw<<AVG_SHIFT.
REQ-022 dir_hi SHALL set when filtered > TH_HIGH and clear when filtered < TH_HIGH-HYST; dir_lo SHALL set when filtered < TH_LOW and clear when filtered > TH_LOW+HYST; otherwise each holds.
REQ-023 hi_pulse/lo_pulse SHALL assert for one cycle, coincident with the 0->1 edge of dir_hi/dir_lo.
REQ-024 Outputs for a channel SHALL update in the cycle after UPDATE; latency drdy -> sample_data/dir = 2 cycles.
REQ-025 DONE SHALL pulse scan_done for one cycle; clearing scan_en mid-scan SHALL let the current scan finish.

Reset
REQ-026 On rst: state IDLE, timer 0, ch 0, drp_den 0, drp_daddr ADDR_BASE, all sample_data/acc 0, first-sample flags set, dir_*/pulses 0, scan_done 0, timeout_err 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; a late drdy after release SHALL be ignored (FSM in IDLE).

Structure
REQ-028 Package joystick_pkg SHALL hold the FSM state enum, default SAMPLE_W, and DRP channel address constants (VAUX6 7'h16, VAUX7 7'h17).
REQ-029 Per-channel filter, hysteresis and pulse logic SHALL be sub-module stick_axis_filter, instantiated NUM_CH times.

Verification
REQ-030 Defaults; XADC model returns X=4000<<4 and Y=2048<<4 with 3-cycle drdy -> first scan: sample_data ch0=4000, dir_hi[0]=1, hi_pulse[0] one cycle, ch1 no direction, scan_done once.
REQ-031 Hysteresis: ch0 filtered 3050 then steps to 2950, 2899 -> dir_hi stays 1 at 2950, clears at 2899; no second hi_pulse until it exceeds 3000 again.
REQ-032 Filter: AVG_SHIFT=2; first raw 0, then raw 4000 repeated -> filtered 1000, 1750, 2312, 2734.
REQ-033 Timeout: model never answers ch1 -> timeout_err=1 after 255 WAIT cycles, ch1 outputs unchanged, scan_done still pulses, next scan reads ch0.
REQ-034 NUM_CH=4, ADDR_BASE=7'h10 -> den pulses at addresses 10,11,12,13 in order, one den per channel per scan.
REQ-035 rst raised during WAIT, drdy arrives after release -> all outputs 0, no capture, next scan starts at the following timer wrap.

Source files
------------

// File: rtl/joystick_pkg.sv
// Shared types and constants for the analog joystick XADC scanner.
// Holds the scan FSM state encoding and the DRP addresses of the stick channels.
package joystick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } scan_state_t;

  localparam int DEF_SAMPLE_W = 12;

  // XADC auxiliary inputs wired to the stick axes
  localparam logic [6:0] ADDR_VAUX6 = 7'h16;
  localparam logic [6:0] ADDR_VAUX7 = 7'h17;

endpackage

// File: rtl/stick_axis_filter.sv
// One stick axis: IIR smoothing of raw XADC samples, hysteretic low/high
// direction levels and one-cycle press pulses on their rising edges.
module stick_axis_filter
  import joystick_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int AVG_SHIFT = 2,
  parameter int TH_LOW    = 1000,
  parameter int TH_HIGH   = 3000,
  parameter int HYST      = 100
) (
  input  logic                clk_100MHz,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] raw,
  output logic [SAMPLE_W-1:0] filtered,
  output logic                dir_lo,
  output logic                dir_hi,
  output logic                lo_pulse,
  output logic                hi_pulse
);

  localparam int ACC_W = SAMPLE_W + AVG_SHIFT;

  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [SAMPLE_W-1:0] filt_next;
  logic                first_reg;
  logic                dir_lo_reg, dir_lo_next;
  logic                dir_hi_reg, dir_hi_next;
  logic                lo_pulse_reg, hi_pulse_reg;
  int                  filt_i;

  // Directions are judged on the post-update value so they move in the same
  // cycle as the filtered sample.
  always_comb begin
    acc_next    = acc_reg;
    dir_lo_next = dir_lo_reg;
    dir_hi_next = dir_hi_reg;
    if (first_reg)
      acc_next = ACC_W'(raw) << AVG_SHIFT;
    else
      acc_next = acc_reg - (acc_reg >> AVG_SHIFT) + ACC_W'(raw);
    filt_next = SAMPLE_W'(acc_next >> AVG_SHIFT);
    filt_i    = int'(filt_next);
    if (filt_i > TH_HIGH)
      dir_hi_next = 1'b1;
    else if (filt_i < TH_HIGH - HYST)
      dir_hi_next = 1'b0;
    if (filt_i < TH_LOW)
      dir_lo_next = 1'b1;
    else if (filt_i > TH_LOW + HYST)
      dir_lo_next = 1'b0;
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      first_reg    <= 1'b1;
      dir_lo_reg   <= 1'b0;
      dir_hi_reg   <= 1'b0;
      lo_pulse_reg <= 1'b0;
      hi_pulse_reg <= 1'b0;
    end else begin
      lo_pulse_reg <= 1'b0;
      hi_pulse_reg <= 1'b0;
      if (sample_valid) begin
        acc_reg      <= acc_next;
        first_reg    <= 1'b0;
        dir_lo_reg   <= dir_lo_next;
        dir_hi_reg   <= dir_hi_next;
        lo_pulse_reg <= dir_lo_next & ~dir_lo_reg;
        hi_pulse_reg <= dir_hi_next & ~dir_hi_reg;
      end
    end
  end

  assign filtered = SAMPLE_W'(acc_reg >> AVG_SHIFT);
  assign dir_lo   = dir_lo_reg;
  assign dir_hi   = dir_hi_reg;
  assign lo_pulse = lo_pulse_reg;
  assign hi_pulse = hi_pulse_reg;

endmodule

// File: rtl/analog_stick_scanner.sv
// Periodically reads NUM_CH XADC auxiliary channels over DRP and feeds each
// result into its own stick_axis_filter; a stalled read is abandoned after TIMEOUT cycles.
module analog_stick_scanner
  import joystick_pkg::*;
#(
  parameter int         NUM_CH    = 2,
  parameter logic [6:0] ADDR_BASE = ADDR_VAUX6,
  parameter int         SAMPLE_W  = DEF_SAMPLE_W,
  parameter int         TH_LOW    = 1000,
  parameter int         TH_HIGH   = 3000,
  parameter int         HYST      = 100,
  parameter int         AVG_SHIFT = 2,
  parameter int         SCAN_DIV  = 1000,
  parameter int         TIMEOUT   = 255
) (
  input  logic                       clk_100MHz,
  input  logic                       rst,
  input  logic                       scan_en,
  output logic [6:0]                 drp_daddr,
  output logic                       drp_den,
  input  logic                       drp_drdy,
  input  logic [15:0]                drp_do,
  output logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  output logic [NUM_CH-1:0]          dir_lo,
  output logic [NUM_CH-1:0]          dir_hi,
  output logic [NUM_CH-1:0]          lo_pulse,
  output logic [NUM_CH-1:0]          hi_pulse,
  output logic                       scan_done,
  output logic                       timeout_err
);

  localparam int CH_W   = 3;
  localparam int TMR_W  = $clog2(SCAN_DIV + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  if (!(TH_LOW + HYST < TH_HIGH - HYST)) begin : g_chk_thresh
    $error("analog_stick_scanner: hysteresis bands of TH_LOW and TH_HIGH overlap");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
    $error("analog_stick_scanner: NUM_CH must be 1..8");
  end
  if (AVG_SHIFT < 0 || AVG_SHIFT > 4) begin : g_chk_shift
    $error("analog_stick_scanner: AVG_SHIFT must be 0..4");
  end
  if (SAMPLE_W < 1 || SAMPLE_W > 16 || SCAN_DIV < 2 || TIMEOUT < 1) begin : g_chk_misc
    $error("analog_stick_scanner: SAMPLE_W, SCAN_DIV or TIMEOUT out of range");
  end

  scan_state_t         state_reg, state_next;
  logic [TMR_W-1:0]    timer_reg;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [SAMPLE_W-1:0] raw_reg, raw_next;
  logic                timeout_err_reg, timeout_err_next;
  logic                tick;
  logic                last_ch;
  logic                unused_do_bits;

  assign tick    = (timer_reg == TMR_W'(SCAN_DIV - 1));
  assign last_ch = (ch_reg == CH_W'(NUM_CH - 1));

  // Free-running scan period; ticks seen outside IDLE are simply lost.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst)
      timer_reg <= '0;
    else if (tick)
      timer_reg <= '0;
    else
      timer_reg <= timer_reg + TMR_W'(1);
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      ch_reg          <= '0;
      wait_cnt_reg    <= '0;
      raw_reg         <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ch_reg          <= ch_next;
      wait_cnt_reg    <= wait_cnt_next;
      raw_reg         <= raw_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ch_next          = ch_reg;
    wait_cnt_next    = wait_cnt_reg;
    raw_next         = raw_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tick && scan_en) begin
          state_next = ST_ISSUE;
          ch_next    = '0;
        end
      end
      ST_ISSUE: begin
        wait_cnt_next = '0;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          raw_next   = drp_do[15 -: SAMPLE_W];
          state_next = ST_UPDATE;
        end else if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
          // Skip this channel; its filter never sees a sample this scan.
          timeout_err_next = 1'b1;
          if (last_ch) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ISSUE;
            ch_next    = ch_reg + CH_W'(1);
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      ST_UPDATE: begin
        if (last_ch) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_ISSUE;
          ch_next    = ch_reg + CH_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        ch_next    = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign drp_den        = (state_reg == ST_ISSUE);
  assign drp_daddr      = ADDR_BASE + 7'(ch_reg);
  assign scan_done      = (state_reg == ST_DONE);
  assign timeout_err    = timeout_err_reg;
  assign unused_do_bits = ^drp_do;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_axis
    stick_axis_filter #(
      .SAMPLE_W  (SAMPLE_W),
      .AVG_SHIFT (AVG_SHIFT),
      .TH_LOW    (TH_LOW),
      .TH_HIGH   (TH_HIGH),
      .HYST      (HYST)
    ) u_filter (
      .clk_100MHz   (clk_100MHz),
      .rst          (rst),
      .sample_valid ((state_reg == ST_UPDATE) && (ch_reg == CH_W'(gi))),
      .raw          (raw_reg),
      .filtered     (sample_data[gi*SAMPLE_W +: SAMPLE_W]),
      .dir_lo       (dir_lo[gi]),
      .dir_hi       (dir_hi[gi]),
      .lo_pulse     (lo_pulse[gi]),
      .hi_pulse     (hi_pulse[gi])
    );
  end

endmodule

// File: tb/tb_analog_stick_scanner.sv
// Directed bench for analog_stick_scanner with a behavioural XADC DRP responder.
// A second, four-channel instance checks DRP address sequencing.
module tb_analog_stick_scanner;

  localparam int SCAN_DIV = 1000;

  logic        clk_100MHz;
  logic        rst;
  logic        scan_en;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [23:0] sample_data;
  logic [1:0]  dir_lo, dir_hi, lo_pulse, hi_pulse;
  logic        scan_done, timeout_err;

  logic        scan_en_b;
  logic [6:0]  daddr_b;
  logic        den_b, drdy_b;
  logic [15:0] do_b;
  logic [47:0] sample_b;
  logic [3:0]  dir_lo_b, dir_hi_b, lo_pulse_b, hi_pulse_b;
  logic        scan_done_b, timeout_err_b;

  analog_stick_scanner dut (
    .clk_100MHz (clk_100MHz), .rst (rst), .scan_en (scan_en),
    .drp_daddr (drp_daddr), .drp_den (drp_den), .drp_drdy (drp_drdy), .drp_do (drp_do),
    .sample_data (sample_data), .dir_lo (dir_lo), .dir_hi (dir_hi),
    .lo_pulse (lo_pulse), .hi_pulse (hi_pulse),
    .scan_done (scan_done), .timeout_err (timeout_err)
  );

  analog_stick_scanner #(.NUM_CH(4), .ADDR_BASE(7'h10), .SCAN_DIV(40)) dut_b (
    .clk_100MHz (clk_100MHz), .rst (rst), .scan_en (scan_en_b),
    .drp_daddr (daddr_b), .drp_den (den_b), .drp_drdy (drdy_b), .drp_do (do_b),
    .sample_data (sample_b), .dir_lo (dir_lo_b), .dir_hi (dir_hi_b),
    .lo_pulse (lo_pulse_b), .hi_pulse (hi_pulse_b),
    .scan_done (scan_done_b), .timeout_err (timeout_err_b)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  // XADC model for the main instance: answers 3 cycles after den
  bit          model_on = 1'b1;
  bit          inject = 1'b0;
  bit          respond1 = 1'b1;
  logic [11:0] raw0, raw1;
  logic [11:0] resp_a;
  int          cnt_a = 0;

  initial begin
    drp_drdy = 1'b0;
    drp_do   = 16'h0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      drp_drdy = 1'b0;
      if (!model_on) cnt_a = 0;
      if (inject) begin
        drp_drdy = 1'b1;
        drp_do   = {12'd999, 4'h5};
      end
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) begin
          drp_drdy = 1'b1;
          drp_do   = {resp_a, 4'hA};
        end
      end
      if (model_on && drp_den) begin
        if (drp_daddr == 7'h16) begin
          cnt_a = 3;
          resp_a = raw0;
        end else if (respond1) begin
          cnt_a = 3;
          resp_a = raw1;
        end
      end
    end
  end

  // XADC model for the four-channel instance: answers 2 cycles after den
  int         cnt_b = 0;
  logic [6:0] pend_b;

  initial begin
    drdy_b = 1'b0;
    do_b   = 16'h0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      drdy_b = 1'b0;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) begin
          drdy_b = 1'b1;
          do_b   = {5'd0, pend_b, 4'h0};
        end
      end
      if (den_b) begin
        cnt_b  = 2;
        pend_b = daddr_b;
      end
    end
  end

  int         n_done, n_den, n_hi, n_lo, lat1, lat2, err_dly;
  logic [6:0] den_addr[$];

  // Runs until one scan_done (plus a short tail) or the cycle budget expires.
  task automatic run_scan(input bit drop_en);
    int cyc = 0;
    int drdy_cyc = -10;
    int den_cyc = 0;
    int tail = -1;
    bit err_before = timeout_err;
    n_done = 0; n_den = 0; n_hi = 0; n_lo = 0;
    lat1 = -1; lat2 = -1; err_dly = -1;
    den_addr.delete();
    while (cyc < 2 * SCAN_DIV + 600 && tail != 0) begin
      @(negedge clk_100MHz);
      cyc++;
      if (drp_den) begin
        den_addr.push_back(drp_daddr);
        n_den++;
        den_cyc = cyc;
        if (drop_en) scan_en = 1'b0;
      end
      if (drp_drdy && drp_daddr == 7'h16 && drdy_cyc < 0) drdy_cyc = cyc;
      if (cyc == drdy_cyc + 1) lat1 = int'(sample_data[11:0]);
      if (cyc == drdy_cyc + 2) lat2 = int'(sample_data[11:0]);
      if (timeout_err && !err_before && err_dly < 0) err_dly = cyc - den_cyc;
      n_hi += int'(hi_pulse[0]);
      n_lo += int'(lo_pulse[0]);
      if (scan_done) begin
        n_done++;
        if (tail < 0) tail = 4;
      end
      if (tail > 0) tail--;
    end
  endtask

  logic [6:0] bq[$];
  int         cnt;
  bit         seen;
  bit         nz;
  int         filt_exp[4] = '{1000, 1750, 2312, 2734};
  logic       lo_exp[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; scan_en = 1'b0; scan_en_b = 1'b0;
    raw0 = 12'd4000; raw1 = 12'd2048;
    repeat (3) @(negedge clk_100MHz);
    rst = 1'b0;
    @(negedge clk_100MHz);
    check_eq("rst_sample", sample_data, 0);
    check_eq("rst_dir", {dir_lo, dir_hi}, 0);
    check_eq("rst_pulse", {lo_pulse, hi_pulse}, 0);
    check_eq("rst_done_err", {scan_done, timeout_err}, 0);
    check_eq("rst_den", drp_den, 0);
    check_eq("rst_daddr", drp_daddr, 7'h16);

    // four-channel address order
    scan_en_b = 1'b1;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 500) begin
      @(negedge clk_100MHz);
      cnt++;
      if (den_b) bq.push_back(daddr_b);
      if (scan_done_b) seen = 1'b1;
    end
    scan_en_b = 1'b0;
    check_eq("b_done", seen, 1);
    check_eq("b_den_count", bq.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("b_addr%0d", i), (i < bq.size()) ? bq[i] : 7'h7f, 7'h10 + i);

    // first scan: X full right, Y centred
    scan_en = 1'b1;
    run_scan(1'b0);
    check_eq("s1_done", n_done, 1);
    check_eq("s1_den", n_den, 2);
    check_eq("s1_addr0", (den_addr.size() > 0) ? den_addr[0] : 7'h7f, 7'h16);
    check_eq("s1_addr1", (den_addr.size() > 1) ? den_addr[1] : 7'h7f, 7'h17);
    check_eq("s1_ch0", sample_data[11:0], 4000);
    check_eq("s1_ch1", sample_data[23:12], 2048);
    check_eq("s1_dir_hi", dir_hi, 2'b01);
    check_eq("s1_dir_lo", dir_lo, 2'b00);
    check_eq("s1_hi_pulse", n_hi, 1);
    check_eq("s1_lat1", lat1, 0);
    check_eq("s1_lat2", lat2, 4000);
    check_eq("s1_err", timeout_err, 0);

    // ch1 never answers
    respond1 = 1'b0;
    run_scan(1'b0);
    check_eq("to_done", n_done, 1);
    check_eq("to_err", timeout_err, 1);
    check_eq("to_delay", err_dly, 256);
    check_eq("to_ch0", sample_data[11:0], 4000);
    check_eq("to_ch1", sample_data[23:12], 2048);
    check_eq("to_dir_hi", dir_hi, 2'b01);

    // recovery scan; scan_en dropped right after its first den
    respond1 = 1'b1;
    run_scan(1'b1);
    check_eq("rc_done", n_done, 1);
    check_eq("rc_den", n_den, 2);
    check_eq("rc_addr0", (den_addr.size() > 0) ? den_addr[0] : 7'h7f, 7'h16);
    check_eq("rc_err_sticky", timeout_err, 1);
    cnt = 0;
    repeat (SCAN_DIV + 100) begin
      @(negedge clk_100MHz);
      if (drp_den) cnt++;
    end
    check_eq("rc_idle_den", cnt, 0);

    // reset in WAIT, stray drdy after release
    raw0 = 12'd3050; raw1 = 12'd2048;
    scan_en = 1'b1;
    cnt = 0;
    while (!drp_den && cnt < 2500) begin
      @(negedge clk_100MHz);
      cnt++;
    end
    check_eq("rw_den_seen", drp_den, 1);
    @(negedge clk_100MHz);
    rst = 1'b1; model_on = 1'b0;
    @(negedge clk_100MHz);
    rst = 1'b0; model_on = 1'b1; inject = 1'b1;
    cnt = 0; nz = 1'b0;
    while (cnt < 3000) begin
      @(negedge clk_100MHz);
      cnt++;
      inject = 1'b0;
      if (sample_data != 0 || dir_hi != 0 || dir_lo != 0 || hi_pulse != 0 || lo_pulse != 0) nz = 1'b1;
      if (drp_den) break;
    end
    check_eq("rw_quiet", nz, 0);
    check_eq("rw_restart", cnt, SCAN_DIV);
    check_eq("rw_err", timeout_err, 0);

    // hysteresis on ch0: 3050, 2950, 2899, 3100
    run_scan(1'b0);
    check_eq("hy1_ch0", sample_data[11:0], 3050);
    check_eq("hy1_dir_hi", dir_hi[0], 1);
    check_eq("hy1_pulse", n_hi, 1);
    raw0 = 12'd2650;
    run_scan(1'b0);
    check_eq("hy2_ch0", sample_data[11:0], 2950);
    check_eq("hy2_dir_hi", dir_hi[0], 1);
    check_eq("hy2_pulse", n_hi, 0);
    raw0 = 12'd2746;
    run_scan(1'b0);
    check_eq("hy3_ch0", sample_data[11:0], 2899);
    check_eq("hy3_dir_hi", dir_hi[0], 0);
    check_eq("hy3_pulse", n_hi, 0);
    raw0 = 12'd3703;
    run_scan(1'b0);
    check_eq("hy4_ch0", sample_data[11:0], 3100);
    check_eq("hy4_dir_hi", dir_hi[0], 1);
    check_eq("hy4_pulse", n_hi, 1);
    check_eq("hy4_ch1", sample_data[23:12], 2048);

    // filter step response from a zero first sample
    @(negedge clk_100MHz);
    rst = 1'b1;
    @(negedge clk_100MHz);
    rst = 1'b0;
    raw0 = 12'd0;
    run_scan(1'b0);
    check_eq("f0_ch0", sample_data[11:0], 0);
    check_eq("f0_dir_lo", dir_lo[0], 1);
    check_eq("f0_lo_pulse", n_lo, 1);
    raw0 = 12'd4000;
    for (int i = 0; i < 4; i++) begin
      run_scan(1'b0);
      check_eq($sformatf("f%0d_ch0", i + 1), sample_data[11:0], filt_exp[i]);
      check_eq($sformatf("f%0d_dir_lo", i + 1), dir_lo[0], lo_exp[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
